// File: rtl/wb_raxm_seq_pkg.sv
// Shared constants and types for the wb_raxm_seq sequential Booth multiplier.
// Optional done interrupt is controlled by the RAXM_IRQ_EN macro (see top).
package raxm_pkg;

  // Register offsets inside the 256-byte decode window
  localparam logic [7:0] OffCtrl   = 8'h00;
  localparam logic [7:0] OffStatus = 8'h04;
  localparam logic [7:0] OffOpA    = 8'h08;
  localparam logic [7:0] OffOpB    = 8'h0C;
  localparam logic [7:0] OffResLo  = 8'h10;
  localparam logic [7:0] OffResHi  = 8'h14;

  // CTRL bit positions
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlModeBit  = 1;
  localparam int unsigned CtrlKLo      = 8;
  localparam int unsigned CtrlKHi      = 12;
  localparam int unsigned CtrlIrqEnBit = 16;

  // STATUS bit positions
  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatDoneBit = 1;
  localparam int unsigned StatErrBit  = 2;

  // FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StDone = 2'd2;

  typedef enum logic [2:0] {DigZero, DigPos1, DigPos2, DigNeg1, DigNeg2} booth_digit_e;

  // Radix-4 recode of triplet {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_e booth_recode(input logic [2:0] t);
    booth_digit_e d;
    unique case (t)
      3'b000, 3'b111: d = DigZero;
      3'b001, 3'b010: d = DigPos1;
      3'b011:         d = DigPos2;
      3'b100:         d = DigNeg2;
      default:        d = DigNeg1;  // 3'b101, 3'b110
    endcase
    return d;
  endfunction

  // Merge write data into an old 32-bit value honouring byte lanes
  function automatic logic [31:0] merge_sel(input logic [31:0] old, input logic [31:0] wdat,
                                            input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~m) | (wdat & m);
  endfunction

endpackage

// File: rtl/wb_raxm_seq_if.sv
// Wishbone slave bus bundle for wb_raxm_seq.
interface wb_raxm_seq_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_raxm_seq_booth_step.sv
// One radix-4 Booth digit: recode a triplet and form A*{0,+-1,+-2} << 2*idx.
module raxm_booth_step
  import raxm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IdxW  = 3
) (
  input  logic [2:0]              triplet_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic [IdxW-1:0]         idx_i,
  output logic signed [2*WIDTH+1:0] pp_o
);

  logic signed [2*WIDTH+1:0] a_ext;
  logic signed [2*WIDTH+1:0] mag;

  // Select the signed multiple of A, then align it to digit position
  always_comb begin
    a_ext = {{(WIDTH+2){a_i[WIDTH-1]}}, a_i};
    unique case (booth_recode(triplet_i))
      DigPos1: mag = a_ext;
      DigPos2: mag = a_ext <<< 1;
      DigNeg1: mag = -a_ext;
      DigNeg2: mag = -(a_ext <<< 1);
      default: mag = '0;
    endcase
    pp_o = mag <<< {idx_i, 1'b0};
  end

endmodule

// File: rtl/wb_raxm_seq.sv
// Wishbone-mapped signed radix-4 Booth multiplier with optional approximation of A.
// Define RAXM_IRQ_EN to build the done interrupt and the CTRL.IRQ_EN bit.
module wb_raxm_seq
  import raxm_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned KMAX      = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  wb_raxm_seq_if.slave wbs,
  output logic         user_irq_o
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned AccW = 2 * WIDTH + 2;
  localparam int unsigned CntW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam int unsigned KLim = (KMAX < WIDTH - 2) ? KMAX : WIDTH - 2;

  state_t                   state_q, state_d;
  logic                     ack_q;
  logic [31:0]              dat_q, dat_d, rdata;
  logic                     mode_q, mode_d;
  logic [4:0]               k_q, k_d, k_eff;
  logic [WIDTH-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
  logic                     done_q, done_d, err_q, err_d;
  logic [PW-1:0]            res_q, res_d;
  logic signed [WIDTH-1:0]  a_cap_q, a_cap_d;
  logic [WIDTH:0]           b_sh_q, b_sh_d;
  logic signed [AccW-1:0]   acc_q, acc_d, pp;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]         lsb_mask, a_trunc, a_round, a_approx;
  logic                     half, req, wr, wr_ctrl, wr_stat, start_req, start_ok, busy;
  logic                     irq_en_rd;
  logic [7:0]               off;
  logic signed [63:0]       res64;
  logic                     unused_acc;

  assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off  = wbs.wbs_adr_i[7:0];
  assign wr   = req & wbs.wbs_we_i;
  assign wr_ctrl   = wr & (off == OffCtrl);
  assign wr_stat   = wr & (off == OffStatus) & wbs.wbs_sel_i[0];
  assign start_req = wr_ctrl & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CtrlStartBit];
  assign start_ok  = start_req & (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign res64     = 64'($signed(res_q));
  assign unused_acc = ^acc_q[AccW-1:PW];

  raxm_booth_step #(
    .WIDTH(WIDTH),
    .IdxW (CntW)
  ) u_booth_step (
    .triplet_i(b_sh_q[2:0]),
    .a_i      (a_cap_q),
    .idx_i    (cnt_q),
    .pp_o     (pp)
  );

  // Register writes, status flags and A approximation
  always_comb begin
    mode_d = (wr_ctrl & wbs.wbs_sel_i[0]) ? wbs.wbs_dat_i[CtrlModeBit] : mode_q;
    k_d    = (wr_ctrl & wbs.wbs_sel_i[1]) ? wbs.wbs_dat_i[CtrlKHi:CtrlKLo] : k_q;
    op_a_d = (wr && off == OffOpA) ?
             WIDTH'(merge_sel(32'(op_a_q), wbs.wbs_dat_i, wbs.wbs_sel_i)) : op_a_q;
    op_b_d = (wr && off == OffOpB) ?
             WIDTH'(merge_sel(32'(op_b_q), wbs.wbs_dat_i, wbs.wbs_sel_i)) : op_b_q;

    done_d = done_q;
    if (wr_stat && wbs.wbs_dat_i[StatDoneBit]) done_d = 1'b0;
    if (start_ok) done_d = 1'b0;
    if (state_q == StDone) done_d = 1'b1;

    err_d = err_q;
    if (wr_stat && wbs.wbs_dat_i[StatErrBit]) err_d = 1'b0;
    if (start_req && busy) err_d = 1'b1;

    // Round to nearest at bit K; fall back to truncation on positive overflow
    k_eff    = (32'(k_d) > KLim) ? 5'(KLim) : k_d;
    lsb_mask = (WIDTH'(1) << k_eff) - WIDTH'(1);
    a_trunc  = op_a_q & ~lsb_mask;
    half     = (k_eff != 5'd0) && ((op_a_q & (WIDTH'(1) << (k_eff - 5'd1))) != '0);
    a_round  = a_trunc + (WIDTH'(1) << k_eff);
    a_approx = (half && !(~a_trunc[WIDTH-1] & a_round[WIDTH-1])) ? a_round : a_trunc;
  end

  // Sequencer: capture, one Booth digit per cycle, then publish the result
  always_comb begin
    state_d = state_q;
    a_cap_d = a_cap_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StBusy;
          a_cap_d = $signed(mode_d ? a_approx : op_a_q);
          b_sh_d  = {op_b_q, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        acc_d  = acc_q + pp;
        b_sh_d = b_sh_q >> 2;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH / 2 - 1)) state_d = StDone;
      end
      StDone: begin
        res_d   = acc_q[PW-1:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read mux; data is registered alongside ack and zero otherwise
  always_comb begin
    rdata = '0;
    unique case (off)
      OffCtrl: begin
        rdata[CtrlModeBit]      = mode_q;
        rdata[CtrlKHi:CtrlKLo]  = k_q;
        rdata[CtrlIrqEnBit]     = irq_en_rd;
      end
      OffStatus: begin
        rdata[StatBusyBit] = busy;
        rdata[StatDoneBit] = done_q;
        rdata[StatErrBit]  = err_q;
      end
      OffOpA:   rdata = 32'(op_a_q);
      OffOpB:   rdata = 32'(op_b_q);
      OffResLo: rdata = res64[31:0];
      OffResHi: rdata = res64[63:32];
      default:  rdata = '0;
    endcase
    dat_d = (req & ~wbs.wbs_we_i) ? rdata : 32'h0;
  end

  // State and register update
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      a_cap_q <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= req;
      dat_q   <= dat_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
      a_cap_q <= a_cap_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

`ifdef RAXM_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en_d = (wr_ctrl & wbs.wbs_sel_i[2]) ? wbs.wbs_dat_i[CtrlIrqEnBit] : irq_en_q;

  // Level interrupt tracks DONE & IRQ_EN on the same edge as DONE
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
    end
  end
  assign irq_en_rd  = irq_en_q;
  assign user_irq_o = irq_q;
`else
  assign irq_en_rd  = 1'b0;
  assign user_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_raxm_seq.sv
// Directed bench for wb_raxm_seq (WIDTH=16).
module tb_wb_raxm_seq;
  localparam logic [31:0] Base = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] rd_v;

  wb_raxm_seq_if bus();

  wb_raxm_seq #(
    .WIDTH    (16),
    .BASE_ADDR(Base),
    .KMAX     (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs       (bus.slave),
    .user_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [7:0] off, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    bit got;
    got  = 1'b0;
    rdat = 32'h0;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = Base | 32'(off);
    bus.wbs_dat_i = wdat;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        got  = 1'b1;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL ack_timeout: observed no ack for offset %02h expected ack", off);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wdat);
    logic [31:0] dummy;
    xfer(1'b1, off, wdat, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    xfer(1'b0, off, 32'h0, 4'hF, v);
    check(tag, v, exp);
  endtask

  initial begin
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    #1;
    check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    #22 rst_n = 1'b1;

    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_status", 8'h04, 32'h0);
    rd_chk("rst_res_lo", 8'h10, 32'h0);
    rd_chk("rst_res_hi", 8'h14, 32'h0);

    // Exact 123 * -45, with DONE pinned one cycle late
    wr(8'h08, 32'd123);
    wr(8'h0C, 32'hFFFF_FFD3);
    rd_chk("opa_rb", 8'h08, 32'h0000_007B);
    rd_chk("opb_rb", 8'h0C, 32'h0000_FFD3);
    wr(8'h00, 32'h0000_0001);
    rd_chk("exact_busy", 8'h04, 32'h1);
    repeat (5) @(posedge clk);
    rd_chk("exact_not_done_c8", 8'h04, 32'h1);
    rd_chk("exact_done", 8'h04, 32'h2);
    rd_chk("exact_lo", 8'h10, 32'hFFFF_EA61);
    rd_chk("exact_hi", 8'h14, 32'hFFFF_FFFF);

    // Approx round-up, K=4; new START clears DONE; DONE visible at cycle 9
    wr(8'h00, 32'h0000_0403);
    rd_chk("approx_busy_done_clr", 8'h04, 32'h1);
    repeat (6) @(posedge clk);
    rd_chk("approx_done_c9", 8'h04, 32'h2);
    rd_chk("ctrl_rb", 8'h00, 32'h0000_0402);
    rd_chk("approx_lo", 8'h10, 32'hFFFF_E980);
    rd_chk("approx_hi", 8'h14, 32'hFFFF_FFFF);

    // K=0 in approx mode is exact
    wr(8'h00, 32'h0000_0003);
    repeat (12) @(posedge clk);
    rd_chk("k0_lo", 8'h10, 32'hFFFF_EA61);

    // Saturation: rounding 0x7FF8 would overflow, truncate to 0x7FF0
    wr(8'h08, 32'h0000_7FF8);
    wr(8'h0C, 32'd2);
    wr(8'h00, 32'h0000_0403);
    repeat (12) @(posedge clk);
    rd_chk("sat_lo", 8'h10, 32'h0000_FFE0);
    rd_chk("sat_hi", 8'h14, 32'h0);

    // K=20 clamps to KMAX=8: 0x1FF -> 0x200, times 3
    wr(8'h08, 32'h0000_01FF);
    wr(8'h0C, 32'd3);
    wr(8'h00, 32'h0000_1403);
    repeat (12) @(posedge clk);
    rd_chk("clamp_lo", 8'h10, 32'h0000_0600);

    // Most-negative squared
    wr(8'h08, 32'h0000_8000);
    wr(8'h0C, 32'h0000_8000);
    wr(8'h00, 32'h0000_0001);
    repeat (12) @(posedge clk);
    rd_chk("minneg_lo", 8'h10, 32'h4000_0000);
    rd_chk("minneg_hi", 8'h14, 32'h0);

    // START while BUSY and OP_A write while BUSY leave the running op alone
    wr(8'h08, 32'd3);
    wr(8'h0C, 32'd5);
    wr(8'h00, 32'h0000_0001);
    wr(8'h08, 32'd7);
    wr(8'h00, 32'h0000_0001);
    repeat (12) @(posedge clk);
    rd_chk("err_status", 8'h04, 32'h6);
    rd_chk("err_res_lo", 8'h10, 32'd15);
    rd_chk("err_opa", 8'h08, 32'd7);
    wr(8'h04, 32'h0000_0006);
    rd_chk("w1c_status", 8'h04, 32'h0);

    // Byte lanes
    xfer(1'b1, 8'h08, 32'h0000_AAAA, 4'b0001, rd_v);
    rd_chk("sel_lane0", 8'h08, 32'h0000_00AA);
    xfer(1'b1, 8'h08, 32'h0000_5500, 4'b0010, rd_v);
    rd_chk("sel_lane1", 8'h08, 32'h0000_55AA);

    // Unmapped offset: reads 0, ack lasts one cycle, dat_o returns to 0
    wr(8'h20, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", 8'h20, 32'h0);
    #10;
    check("ack_single", 32'(bus.wbs_ack_o), 32'h0);
    check("dat_idle", bus.wbs_dat_o, 32'h0);

    // Interrupt
    wr(8'h08, 32'd2);
    wr(8'h0C, 32'd3);
    wr(8'h00, 32'h0001_0001);
    repeat (12) @(posedge clk);
    rd_chk("irq_res_lo", 8'h10, 32'd6);
`ifdef RAXM_IRQ_EN
    check("irq_high", 32'(irq), 32'h1);
    rd_chk("irq_ctrl", 8'h00, 32'h0001_0000);
    wr(8'h04, 32'h0000_0002);
    check("irq_low", 32'(irq), 32'h0);
`else
    check("irq_tied", 32'(irq), 32'h0);
    rd_chk("irq_ctrl", 8'h00, 32'h0);
`endif

    // Reset mid-operation
    wr(8'h08, 32'd5);
    wr(8'h0C, 32'd5);
    wr(8'h00, 32'h0000_0001);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(bus.wbs_ack_o), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    #10 rst_n = 1'b1;
    rd_chk("midrst_status", 8'h04, 32'h0);
    rd_chk("midrst_res_lo", 8'h10, 32'h0);
    rd_chk("midrst_opa", 8'h08, 32'h0);
    rd_chk("midrst_ctrl", 8'h00, 32'h0);
    repeat (12) @(posedge clk);
    rd_chk("midrst_no_done", 8'h04, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_raxm_seq.md
Name: wb_raxm_seq

Overview:
- Parametrised successor to the single-width Wishbone approximate multiplier.
- Wishbone-slave, signed, sequential radix-4 Booth multiplier; operand width set at elaboration.
- Runtime-selectable exact or approximate mode, with programmable approximation depth K.
- Busy/done status; register-mapped in the user-project Wishbone space.

Parameters:
- WIDTH, 16: operand width in bits; even, 4..32. Product is 2*WIDTH bits.
- BASE_ADDR, 32'h3000_0000: Wishbone base address; decode uses adr[31:8].
- KMAX, 8: maximum approximation depth; CTRL.K is clamped to min(K, KMAX, WIDTH-2).

Ports:
- wb_clk_i, in, 1: sole clock.
- wb_rst_ni, in, 1: asynchronous, active-low reset.
- wbs_cyc_i, in, 1: Wishbone cycle.
- wbs_stb_i, in, 1: Wishbone strobe.
- wbs_we_i, in, 1: write enable.
- wbs_sel_i, in, 4: byte lane selects.
- wbs_adr_i, in, 32: byte address.
- wbs_dat_i, in, 32: write data.
- wbs_ack_o, out, 1: acknowledge.
- wbs_dat_o, out, 32: read data.
- user_irq_o, out, 1: done interrupt (see Optional Feature).

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 MODE (0 exact, 1 approx); bits[12:8] K; bit16 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (write-1-to-clear); bit2 ERR (write-1-to-clear).
  - 0x08 OP_A: low WIDTH bits used.
  - 0x0C OP_B: low WIDTH bits used.
  - 0x10 RES_LO, 0x14 RES_HI: RO; 2*WIDTH product sign-extended to 64 bits.
  - Unmapped offsets inside the decode window read 0; writes to them are ignored; ack is still returned.
- Wishbone handshake:
  - ack is registered, asserted the cycle after cyc&stb&!ack, held exactly one cycle.
  - Each request gets exactly one ack.
  - Writes honour sel byte lanes.
  - dat_o is valid with ack and is 0 otherwise.
- Reset values: all registers, result, ack, dat_o and irq are 0; FSM is IDLE.
- FSM:
  - IDLE -> BUSY on START write. On entry, OP_A is captured (approximated if MODE=1), OP_B is captured, and the accumulator and counter are cleared.
  - BUSY: one Booth digit of OP_B per cycle (radix-4, triplet b[2i+1:2i-1], b[-1]=0). Partial product A*{0,±1,±2} is shifted by 2i and accumulated. WIDTH/2 cycles.
  - DONE: result registers written, DONE=1 set; then return to IDLE. DONE stays set until cleared.
  - Latency: START ack cycle to DONE=1 is WIDTH/2+1 cycles.
- Approximation (MODE=1):
  - A' = A with bits[K-1:0] cleared; if A[K-1]=1, add 2^K (round to nearest).
  - If the rounded value would exceed the signed maximum, the truncated value is used instead.
  - K=0 gives an exact result.
  - Only A is approximated; B is always exact.
- Boundary conditions:
  - START while BUSY: ignored, ERR set; the operation in flight is unaffected.
  - Writes to OP_A/OP_B while BUSY update the registers but not the captured operands.
  - START and a DONE W1C in the same write: DONE is cleared, then the new operation begins.
  - A new START clears DONE.
  - Reset asserted mid-operation: immediate return to IDLE, results zeroed, no DONE.
  - Most-negative operands: -2^(WIDTH-1) * -2^(WIDTH-1) gives the correct positive 2*WIDTH-bit result.

Optional Feature:
- Macro RAXM_IRQ_EN.
- Defined: user_irq_o is a registered level = DONE & IRQ_EN; it falls when DONE is cleared.
- Undefined: user_irq_o is tied to 0, the IRQ_EN bit reads 0, and no irq logic is generated.

Decomposition:
- Package raxm_pkg:
  - register offset constants;
  - CTRL/STATUS bit-index constants;
  - FSM state enum (IDLE, BUSY, DONE);
  - Booth digit enum.
- One sub-module, raxm_booth_step: combinational Booth recode plus partial-product generation for one digit.
  - Inputs: triplet, A', shift index.
  - Output: signed 2*WIDTH+2 partial product.
- The top module holds the Wishbone decode, registers, FSM and accumulator.

Test Plan (WIDTH=16):
- Exact: A=123, B=-45, MODE=0, START -> BUSY for 8 cycles, DONE at cycle 9; RES_LO=0xFFFFEA61, RES_HI=0xFFFFFFFF.
- Approx round-up: A=123, B=-45, MODE=1, K=4 -> A'=128; RES_LO=0xFFFFE980.
- Approx saturation: A=0x7FF8, B=2, MODE=1, K=4 -> A'=0x7FF0; RES_LO=0x0000FFE0.
- Corner case: A=B=0x8000 exact -> RES_LO=0x40000000, RES_HI=0.
- START during BUSY -> ERR=1, first result intact; W1C of STATUS=0x6 clears DONE and ERR.
- Reset/handshake:
  - wb_rst_ni low mid-BUSY -> all registers 0, BUSY=0.
  - Read of offset 0x20 -> data 0, single-cycle ack.
  - With RAXM_IRQ_EN and IRQ_EN=1 -> user_irq_o rises with DONE and falls on W1C.
